// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix lines toward the keypad plus the
// accepted-key / entered-number outputs toward the display side.
interface keypad_scanner_if;
  logic [3:0]  key_row;    // row lines, active-low, asynchronous to clk
  logic [3:0]  key_col;    // column drive, active-low one-hot
  logic [3:0]  key_code;   // last accepted key {row_idx, col_idx}
  logic        key_valid;  // one-clk pulse per accepted press
  logic [15:0] value;      // entered number, 0..9999

  // scanner side
  modport master (
    input  key_row,
    output key_col, key_code, key_valid, value
  );

  // keypad / display side
  modport slave (
    output key_row,
    input  key_col, key_code, key_valid, value
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, full-scan debounce FSM and a
// 4-digit decimal entry register (digits shift in, 10 = clear, 11 = backspace).
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int TCK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  // Running result of a scan: n is the key count saturated at 2 (MULTI),
  // code is only meaningful when n == 1.
  typedef struct packed {
    logic [1:0] n;
    logic [3:0] code;
  } scan_t;

  logic [3:0]       row_s1, row_s2;
  logic [TCK_W-1:0] tick_cnt;
  logic             tick;
  logic [1:0]       col_idx;
  scan_t            acc, scan_nxt;
  logic             scan_close;
  state_t           state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [3:0]       cand;
  logic [3:0]       key_code_r;
  logic             key_valid_r;
  logic [15:0]      value_r;
  logic [16:0]      val_nxt;
  logic [2:0]       hits, sum;
  logic [1:0]       hit_row;

  assign tick       = (tick_cnt == TCK_W'(SCAN_DIV - 1));
  assign scan_close = tick && (col_idx == 2'd3);
  assign cnt_inc    = cnt + 1'b1;

  assign kp.key_col   = ~(4'b0001 << col_idx);
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.value     = value_r;

  // Two-flop synchronizer for the asynchronous row lines (idle high)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= kp.key_row;
      row_s2 <= row_s1;
    end
  end

  // Scan tick divider: wraps at SCAN_DIV-1, tick is high on that count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // Column pointer advances once per tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    col_idx <= 2'd0;
    else if (tick) col_idx <= col_idx + 2'd1;
  end

  // Merge the current column's low rows into the running scan result
  always_comb begin
    hits    = 3'd0;
    hit_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2[r]) begin
        hits    = hits + 3'd1;
        hit_row = 2'(r);
      end
    end
    sum           = {1'b0, acc.n} + hits;
    scan_nxt.n    = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    scan_nxt.code = (acc.n != 2'd0) ? acc.code : {hit_row, col_idx};
  end

  // Scan accumulator: collects columns 0..2, cleared when the scan closes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          acc <= '0;
    else if (scan_close) acc <= '0;
    else if (tick)       acc <= scan_nxt;
  end

  // Debounce FSM, stepped once per full scan; MULTI blocks a press but
  // also keeps a held key from being seen as released
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= 4'd0;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (scan_close) begin
        case (state)
          IDLE: begin
            if (scan_nxt.n == 2'd1) begin
              cand <= scan_nxt.code;
              if (DEBOUNCE_SCANS <= 1) begin
                key_code_r  <= scan_nxt.code;
                key_valid_r <= 1'b1;
                state       <= HELD;
                cnt         <= '0;
              end else begin
                state <= DEBOUNCE;
                cnt   <= CNT_W'(1);
              end
            end
          end
          DEBOUNCE: begin
            if (scan_nxt.n == 2'd1 && scan_nxt.code == cand) begin
              if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                key_code_r  <= cand;
                key_valid_r <= 1'b1;
                state       <= HELD;
                cnt         <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          HELD: begin
            if (scan_nxt.n == 2'd0) begin
              if (DEBOUNCE_SCANS <= 1) begin
                state <= IDLE;
                cnt   <= '0;
              end else begin
                state <= RELEASE;
                cnt   <= CNT_W'(1);
              end
            end
          end
          RELEASE: begin
            if (scan_nxt.n == 2'd0) begin
              if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                state <= IDLE;
                cnt   <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= HELD;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Next entered number for the key just accepted (17-bit to avoid truncation)
  always_comb begin
    val_nxt = {1'b0, value_r};
    if (key_valid_r) begin
      if (key_code_r <= 4'd9)
        val_nxt = ((({1'b0, value_r} < 17'd1000) ? {1'b0, value_r}
                    : ({1'b0, value_r} % 17'd1000)) * 17'd10)
                  + {13'd0, key_code_r};
      else if (key_code_r == 4'd10)
        val_nxt = 17'd0;
      else if (key_code_r == 4'd11)
        val_nxt = {1'b0, value_r} / 17'd10;
    end
  end

  // Entered number register, one clk behind key_valid; clamp guards 9999
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) value_r <= 16'd0;
    else        value_r <= (val_nxt > 17'd9999) ? 16'd9999 : val_nxt[15:0];
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2): a keypad matrix
// model drives the rows from a pressed-key mask, and a scan-level model
// predicts pulses, key_code and value.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DS = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] mask = 16'h0;

  int checks = 0;
  int errors = 0;
  int pulses_total = 0;

  // scan-level reference state
  bit m_held = 0;
  int m_run  = 0;
  int m_cand = 0;
  int exp_code  = 0;
  int exp_value = 0;

  always #5 clk = ~clk;

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif.master)
  );

  // Matrix: a pressed key {r,c} pulls row r low while column c is driven low
  always_comb begin
    kif.key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.key_col[c] && mask[r*4+c]) kif.key_row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one scan's worth of decision to the reference; returns 1 on a press
  task automatic model_scan(input logic [15:0] m, output bit accepted);
    int n, code;
    n = $countones(m);
    code = 0;
    for (int k = 0; k < 16; k++) if (m[k]) code = k;
    accepted = 0;
    if (!m_held) begin
      if (n == 1 && (m_run == 0 || code == m_cand)) begin
        m_cand = code;
        m_run++;
        if (m_run == DS) begin
          accepted = 1;
          m_held = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (n == 0) begin
        m_run++;
        if (m_run == DS) begin
          m_held = 0;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    if (accepted) begin
      exp_code = m_cand;
      if (m_cand < 10)       exp_value = (exp_value % 1000) * 10 + m_cand;
      else if (m_cand == 10) exp_value = 0;
      else if (m_cand == 11) exp_value = exp_value / 10;
    end
  endtask

  // Hold mask m for one full scan (16 clks), sampling on falling edges
  task automatic run_scan(input logic [15:0] m, input bit chk_col);
    int np;
    bit acc;
    logic [3:0] ec;
    mask = m;
    np = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (kif.key_valid) np++;
      if (i == 1) chk("value", kif.value, exp_value);
      if (chk_col) begin
        ec = 4'hF ^ (4'd1 << ((i / 4) % 4));
        chk("key_col", kif.key_col, ec);
      end
    end
    model_scan(m, acc);
    pulses_total += np;
    chk("pulses", np, acc ? 1 : 0);
    chk("key_code", kif.key_code, exp_code);
  endtask

  task automatic press_key(input int code);
    logic [15:0] m;
    m = 16'd1 << code;
    run_scan(m, 0);
    run_scan(m, 0);
    run_scan(16'h0, 0);
    run_scan(16'h0, 0);
  endtask

  // One-clk reset pulse at a scan boundary; checks outputs while asserted
  task automatic do_reset();
    reset = 1'b0;
    mask = 16'h0;
    #1;
    chk("rst_key_col", kif.key_col, 4'b1110);
    chk("rst_key_code", kif.key_code, 0);
    chk("rst_key_valid", kif.key_valid, 0);
    chk("rst_value", kif.value, 0);
    @(negedge clk);
    reset = 1'b1;
    m_held = 0; m_run = 0; exp_code = 0; exp_value = 0;
  endtask

  initial begin
    int base;
    int kind, reps, a, b;
    logic [15:0] rm;

    // reset and idle scanning
    repeat (3) @(negedge clk);
    chk("rst_key_col", kif.key_col, 4'b1110);
    chk("rst_key_valid", kif.key_valid, 0);
    chk("rst_value", kif.value, 0);
    reset = 1'b1;
    run_scan(16'h0, 1);
    run_scan(16'h0, 1);
    chk("idle_pulses", pulses_total, 0);

    // key {1,2} held three scans: one pulse, code 6, value 6
    base = pulses_total;
    run_scan(16'd1 << 6, 0);
    run_scan(16'd1 << 6, 0);
    run_scan(16'd1 << 6, 0);
    chk("hold_one_pulse", pulses_total - base, 1);
    chk("hold_code", kif.key_code, 6);
    run_scan(16'h0, 0);
    run_scan(16'h0, 0);
    chk("hold_value", kif.value, 6);

    // digit entry, overflow drop, backspace, clear
    press_key(10); chk("clr", kif.value, 0);
    press_key(1);  chk("d1", kif.value, 1);
    press_key(2);  chk("d12", kif.value, 12);
    press_key(3);  chk("d123", kif.value, 123);
    press_key(4);  chk("d1234", kif.value, 1234);
    press_key(5);  chk("d2345", kif.value, 2345);
    press_key(11); chk("bksp", kif.value, 234);
    press_key(10); chk("clr2", kif.value, 0);
    press_key(11); chk("bksp0", kif.value, 0);
    press_key(13); chk("nochg", kif.value, 0);

    // bounce before the second scan, then stable
    base = pulses_total;
    run_scan(16'h0001, 0);
    run_scan(16'h0000, 0);
    chk("bounce_none", pulses_total - base, 0);
    run_scan(16'h0001, 0);
    run_scan(16'h0001, 0);
    chk("bounce_one", pulses_total - base, 1);
    chk("bounce_code", kif.key_code, 0);
    run_scan(16'h0, 0);
    run_scan(16'h0, 0);

    // two keys together, then change keys while held
    base = pulses_total;
    repeat (5) run_scan(16'h0006, 0);
    chk("multi_none", pulses_total - base, 0);
    run_scan(16'h0002, 0);
    run_scan(16'h0002, 0);
    chk("multi_acc", pulses_total - base, 1);
    chk("multi_code", kif.key_code, 1);
    run_scan(16'h0006, 0);
    run_scan(16'h0006, 0);
    run_scan(16'h0004, 0);
    run_scan(16'h0004, 0);
    run_scan(16'h0000, 0);
    run_scan(16'h0004, 0);
    chk("held_no_repeat", pulses_total - base, 1);
    run_scan(16'h0000, 0);
    run_scan(16'h0000, 0);
    run_scan(16'h0004, 0);
    run_scan(16'h0004, 0);
    chk("after_release", pulses_total - base, 2);
    chk("after_code", kif.key_code, 2);
    run_scan(16'h0, 0);
    run_scan(16'h0, 0);

    // reset mid-DEBOUNCE and mid-HELD
    base = pulses_total;
    run_scan(16'd1 << 5, 0);
    do_reset();
    run_scan(16'h0, 1);
    run_scan(16'h0, 1);
    chk("rst_deb_pulses", pulses_total - base, 0);
    run_scan(16'd1 << 12, 0);
    run_scan(16'd1 << 12, 0);
    run_scan(16'd1 << 12, 0);
    base = pulses_total;
    do_reset();
    run_scan(16'h0, 1);
    run_scan(16'h0, 1);
    chk("rst_held_pulses", pulses_total - base, 0);
    chk("rst_held_value", kif.value, 0);
    chk("rst_held_code", kif.key_code, 0);

    // random scan sequences against the reference
    for (int s = 0; s < 70; s++) begin
      kind = int'($urandom_range(0, 99));
      reps = int'($urandom_range(1, 3));
      a = int'($urandom_range(0, 15));
      b = (a + int'($urandom_range(1, 15))) % 16;
      if (kind < 40)      rm = 16'h0;
      else if (kind < 85) rm = 16'd1 << a;
      else                rm = (16'd1 << a) | (16'd1 << b);
      repeat (reps) run_scan(rm, 0);
    end
    run_scan(16'h0, 0);
    run_scan(16'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles per column scan tick (1 kHz at 100 MHz).
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive identical full scans required to accept a press or a release.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock, all logic on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port key_row, input, 4 bits: keypad row lines, active-low, asynchronous to clk.
REQ-006 The block SHALL have port key_col, output, 4 bits: keypad column drive, active-low one-hot.
REQ-007 The block SHALL have port key_code, output, 4 bits: last accepted key, {row_idx[1:0], col_idx[1:0]}.
REQ-008 The block SHALL have port key_valid, output, 1 bit: one-clk pulse per accepted press.
REQ-009 The block SHALL have port value, output, 16 bits: binary entered number, 0..9999, for the display driver.

Function
REQ-010 key_row SHALL pass a 2-flop synchronizer before any use.
REQ-011 A tick counter SHALL count 0..SCAN_DIV-1 and wrap, asserting an internal tick for one clk at SCAN_DIV-1.
REQ-012 col_idx SHALL advance 0->1->2->3->0 on each tick; key_col = 1110, 1101, 1011, 0111 for col_idx 0..3.
REQ-013 On each tick, before col_idx advances, synchronized rows SHALL be sampled for the current column; a low row r marks key {r,col_idx} pressed.
REQ-014 The tick at col_idx==3 SHALL close a full scan: result NONE (0 keys), SINGLE(code) (exactly 1 key), MULTI (>=2 keys).
REQ-015 MULTI SHALL be treated as NONE for pressing (no acceptance) and as NOT-NONE for release.
REQ-016 FSM states: IDLE, DEBOUNCE, HELD, RELEASE; evaluated only at full-scan close.
REQ-017 IDLE: SINGLE(c) -> DEBOUNCE, cand=c, cnt=1; otherwise stay.
REQ-018 DEBOUNCE: SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> key_code=cand, key_valid=1 one clk, -> HELD; any other result -> IDLE.
REQ-019 DEBOUNCE_SCANS=1 SHALL accept on the first SINGLE scan (IDLE->HELD directly with pulse).
REQ-020 HELD: NONE -> RELEASE, cnt=1; otherwise stay (key change while held SHALL produce no new event; no auto-repeat).
REQ-021 RELEASE: NONE -> cnt+1, at DEBOUNCE_SCANS -> IDLE; any non-NONE -> HELD.
REQ-022 value SHALL update on the clk edge after key_valid (one-clk latency) per key_code:
 - 0..9 (digit d): value<1000 -> value*10+d; else (value mod 1000)*10+d (oldest digit drops).
 - 10: clear, value=0.
 - 11: backspace, value=value/10 (0 stays 0).
 - 12..15: no change.
REQ-023 value SHALL never exceed 9999; intermediate arithmetic SHALL be at least 17 bits wide with no truncation of the result.
REQ-024 key_code SHALL hold its last accepted value until the next acceptance.

Reset
REQ-025 While reset is low: key_col=1110, key_code=0, key_valid=0, value=0, FSM=IDLE, tick counter=0, col_idx=0, cnt=0, synchronizer flops=1111.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL discard the candidate with no key_valid pulse; after release the scan restarts at column 0.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2)
REQ-027 After reset release, key_row=1111 -> key_col cycles 1110,1101,1011,0111 every 4 clks; key_valid never asserts; value=0.
REQ-028 Hold key {1,2} (row1 low while key_col=1011) for 3 scans -> exactly one key_valid pulse, key_code=6; next clk value=6.
REQ-029 Enter 1,2,3,4,5 with full releases -> value 1,12,123,1234,2345; then code 11 -> 234; code 10 -> 0; code 11 at 0 -> 0.
REQ-030 Press {0,0}, then bounce (one NONE scan) before the 2nd scan -> no pulse; stable 2 scans -> one pulse, key_code=0.
REQ-031 Hold {0,1} and {0,2} together 5 scans -> no pulse; accept {0,1}, then add {0,2} and release {0,1} while held -> no second pulse until a full 2-scan release.
REQ-032 Assert reset for 1 clk mid-DEBOUNCE and mid-HELD -> no pulse, all outputs at REQ-025 values, and value stays 0.
